// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard controller.
// The datapath side uses the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] rs1D, rs2D, rs1E, rs2E;
    logic [REG_ADDR_W-1:0] RdE, RdM, RdW;
    logic                  MemReadE, RegWriteM, RegWriteW, PCSrcE;
    logic                  mem_req_M, mem_ready;
    logic [1:0]            ForwardAE, ForwardBE;
    logic                  StallF, StallD, StallE;
    logic                  FlushF, FlushD, FlushW;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW,
        output MemReadE, RegWriteM, RegWriteW, PCSrcE, mem_req_M, mem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushF, FlushD, FlushW, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW,
        input  MemReadE, RegWriteM, RegWriteW, PCSrcE, mem_req_M, mem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushF, FlushD, FlushW, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: E-stage forwarding, load-use bubble, branch flush and memory freeze
// with timeout watchdog. Optional performance counters enabled by HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    localparam int TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mem_err_q, mem_err_d;
    logic             lw_stall, mem_stall;
    logic             stall_f, stall_e, flush_f;

    logic [REG_ADDR_W-1:0] rs_e [2];
    logic [1:0]            fwd  [2];

    assign rs_e[0] = hz.rs1E;
    assign rs_e[1] = hz.rs2E;

    // M has priority over W because it carries the younger write to the same register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        always_comb begin
            fwd[gi] = 2'b00;
            if (hz.RegWriteM && hz.RdM != '0 && hz.RdM == rs_e[gi])
                fwd[gi] = 2'b10;
            else if (hz.RegWriteW && hz.RdW != '0 && hz.RdW == rs_e[gi])
                fwd[gi] = 2'b01;
        end
    end

    always_comb begin
        lw_stall  = hz.MemReadE && hz.RdE != '0 &&
                    (hz.RdE == hz.rs1D || hz.RdE == hz.rs2D) && !hz.PCSrcE;
        mem_stall = hz.mem_req_M && !hz.mem_ready && state_q != S_ERR;
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign stall_f = rst_n & (lw_stall | mem_stall);
    assign stall_e = rst_n & mem_stall;
    assign flush_f = rst_n & hz.PCSrcE & !mem_stall;

    assign hz.ForwardAE = fwd[0] & {2{rst_n}};
    assign hz.ForwardBE = fwd[1] & {2{rst_n}};
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_f;
    assign hz.StallE    = stall_e;
    assign hz.FlushF    = flush_f;
    assign hz.FlushD    = rst_n & (lw_stall | hz.PCSrcE) & !mem_stall;
    assign hz.FlushW    = rst_n & (mem_stall | state_q == S_ERR);
    assign hz.mem_err   = rst_n & (mem_err_q | state_q == S_ERR);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_RUN: begin
                if (mem_stall) begin
                    state_d = S_MEM_WAIT;
                    timer_d = TMR_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (hz.mem_ready || !hz.mem_req_M) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_ERR: begin
                state_d   = S_RUN;
                timer_d   = '0;
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            timer_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_f || stall_e) && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_f && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4): expected output vectors are queued
// when a cycle's stimulus is driven and compared at the following falling edge.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

    hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // {FA[1:0], FB[1:0], StallF, StallD, StallE, FlushF, FlushD, FlushW, mem_err}
    localparam logic [10:0] NONE  = 11'b00_00_0_0_0_0_0_0_0;
    localparam logic [10:0] MEM   = 11'b00_00_1_1_1_0_0_1_0;
    localparam logic [10:0] LW    = 11'b00_00_1_1_0_0_1_0_0;
    localparam logic [10:0] BR    = 11'b00_00_0_0_0_1_1_0_0;
    localparam logic [10:0] FW    = 11'b00_00_0_0_0_0_0_1_0;
    localparam logic [10:0] ME    = 11'b00_00_0_0_0_0_0_0_1;

`ifdef HAZ_PERF_CNT_EN
    localparam int EXP_STALL_CNT = 3;
    localparam int EXP_FLUSH_CNT = 1;
`else
    localparam int EXP_STALL_CNT = 0;
    localparam int EXP_FLUSH_CNT = 0;
`endif

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];

    function automatic logic [10:0] obs_vec();
        return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
                hz.FlushF, hz.FlushD, hz.FlushW, hz.mem_err};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0;
        hz.RdE  = '0; hz.RdM  = '0; hz.RdW  = '0;
        hz.MemReadE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.PCSrcE = 1'b0; hz.mem_req_M = 1'b0; hz.mem_ready = 1'b0;
    endtask

    // Inputs are already driven (just after a rising edge); compare at the falling edge.
    task automatic step(input string tag, input logic [10:0] exp);
        exp_t e;
        sb.push_back('{tag, exp});
        @(negedge clk);
        e = sb.pop_front();
        chk(e.tag, {53'd0, obs_vec()}, {53'd0, e.exp});
        $display("cycle %-12s out=%011b exp=%011b", e.tag, obs_vec(), e.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag, input int s, input int f);
        chk({tag, "_stall_cnt"}, {32'd0, hz.stall_cnt}, 64'(s));
        chk({tag, "_flush_cnt"}, {32'd0, hz.flush_cnt}, 64'(f));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=done");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with hazard-provoking inputs: every output must stay low.
        idle();
        hz.mem_req_M = 1'b1; hz.PCSrcE = 1'b1;
        hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.rs1E = 5'd5;
        hz.MemReadE = 1'b1; hz.RdE = 5'd7; hz.rs2D = 5'd7;
        @(negedge clk);
        chk("reset_outs", {53'd0, obs_vec()}, 64'd0);
        chk_cnts("reset", 0, 0);
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        step("idle", NONE);

        // Forwarding
        hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
        hz.rs1E = 5'd5; hz.rs2E = 5'd5;
        step("fwd_m_prio", 11'b10_10_0000000);
        hz.RdM = 5'd0;
        step("fwd_w_rdm0", 11'b01_01_0000000);
        hz.RdW = 5'd0; hz.rs1E = 5'd0; hz.rs2E = 5'd0;
        step("fwd_x0", NONE);
        hz.RdM = 5'd4; hz.rs1E = 5'd4; hz.RdW = 5'd3; hz.rs2E = 5'd3;
        step("fwd_split", 11'b10_01_0000000);
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        step("fwd_nowrite", NONE);
        idle();

        // Three-cycle memory freeze, then one taken branch
        hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mem_wait", MEM);
        hz.mem_ready = 1'b1;
        step("mem_done", NONE);
        idle();
        hz.PCSrcE = 1'b1;
        step("branch", BR);
        idle();
        chk_cnts("perf", EXP_STALL_CNT, EXP_FLUSH_CNT);

        // Load-use
        hz.MemReadE = 1'b1; hz.RdE = 5'd7; hz.rs2D = 5'd7;
        step("lw_use_rs2", LW);
        hz.MemReadE = 1'b0;
        step("lw_gone", NONE);
        hz.MemReadE = 1'b1; hz.PCSrcE = 1'b1;
        step("lw_branch", BR);
        idle();
        hz.MemReadE = 1'b1; hz.RdE = 5'd7; hz.rs1D = 5'd7;
        step("lw_use_rs1", LW);
        hz.RdE = 5'd0; hz.rs1D = 5'd0;
        step("lw_x0", NONE);
        idle();

        // Branch resolved while frozen: flush fires on the release cycle only
        hz.mem_req_M = 1'b1; hz.mem_ready = 1'b0; hz.PCSrcE = 1'b1;
        for (int i = 0; i < 2; i++) step("frozen_br", MEM);
        hz.mem_ready = 1'b1;
        step("release_br", BR);
        idle();

        // Request withdrawn mid-wait, then a zero-wait access
        hz.mem_req_M = 1'b1;
        for (int i = 0; i < 2; i++) step("drop_wait", MEM);
        hz.mem_req_M = 1'b0;
        step("drop_req", NONE);
        hz.mem_req_M = 1'b1; hz.mem_ready = 1'b1;
        step("zero_wait", NONE);
        hz.mem_ready = 1'b0;

        // Timeout: four frozen cycles, one ERR cycle, sticky error
        for (int i = 0; i < 4; i++) step("tmo_wait", MEM);
        step("tmo_err", FW | ME);
        hz.mem_req_M = 1'b0;
        step("err_sticky", ME);
        step("err_sticky2", ME);

        // Asynchronous reset in the middle of a memory wait
        hz.mem_req_M = 1'b1;
        for (int i = 0; i < 2; i++) step("pre_rst", MEM | ME);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {53'd0, obs_vec()}, 64'd0);
        chk_cnts("rst_async", 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("post_rst", MEM);
        hz.mem_ready = 1'b1;
        step("post_rst_ok", NONE);
        idle();
        step("final_idle", NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
